// File: rtl/parking_pkg.sv
// Shared types, default cycle counts and width helpers for the parking-ticket sequencer.
package parking_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ARMED,
      ST_SEND,
      ST_WAIT_ACK,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam int unsigned DEF_INIT_CYC        = 1000;
   localparam int unsigned DEF_DEBOUNCE_CYC    = 50000;
   localparam int unsigned DEF_GRACE_CYC       = 5000000;
   localparam int unsigned DEF_PULSE_CYC       = 100;
   localparam int unsigned DEF_ACK_TIMEOUT_CYC = 1000000;
   localparam int unsigned DEF_MAX_RETRY       = 3;
   localparam int unsigned DEF_CNT_W           = 8;

   function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counters only ever reach max_cyc-1, so $clog2(max_cyc) bits suffice.
   function automatic int unsigned timer_width(input int unsigned max_cyc);
      return (max_cyc > 1) ? $clog2(max_cyc) : 1;
   endfunction

endpackage

// File: rtl/parking_ticket_sequencer_debouncer.sv
// Bay-sensor front end: 2-flop synchroniser followed by a consecutive-cycle debouncer.
// sensor_db only moves after the synchronised input has disagreed with it for
// DEBOUNCE_CYC cycles in a row; rise/fall pulse for one cycle alongside that move.
module sensor_debouncer
   import parking_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_in,
   output logic sensor_db,
   output logic rise,
   output logic fall
);

   localparam int unsigned DB_W = timer_width(DEBOUNCE_CYC);

   logic [1:0]      sync_q;
   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            db_q, db_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   // Bring the raw pin into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], sensor_in};
   end

   // Count consecutive disagreeing samples; any agreeing sample restarts the count.
   always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync_q[1] != db_q) begin
         if (cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_d   = sync_q[1];
            rise_d = sync_q[1];
            fall_d = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         db_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sensor_db = db_q;
   assign rise      = rise_q;
   assign fall      = fall_q;

endmodule

// File: rtl/parking_ticket_sequencer.sv
// Parking-ticket ESP8266 link sequencer: debounced bay sensor, grace timer,
// timed send pulse, acknowledge wait with optional retries, sticky fault.
// Build option: define TICKET_RETRY_EN to enable re-sends after an ack timeout
// (and the led blink during a retry send); otherwise the first timeout faults.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | AT-command window after reset, cmd_mode high
// IDLE     | bay empty or ticket already issued for this car, waiting for rise
// ARMED    | car present, grace timer running
// SEND     | esp_send pulse active
// WAIT_ACK | pulse done, waiting for esp_ack or timeout
// DONE     | ticket acknowledged, waiting for the car to leave
// FAULT    | ESP unresponsive, held until reset
module parking_ticket_sequencer
   import parking_pkg::*;
#(
   parameter int unsigned INIT_CYC        = DEF_INIT_CYC,
   parameter int unsigned DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
   parameter int unsigned GRACE_CYC       = DEF_GRACE_CYC,
   parameter int unsigned PULSE_CYC       = DEF_PULSE_CYC,
   parameter int unsigned ACK_TIMEOUT_CYC = DEF_ACK_TIMEOUT_CYC,
   parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor_in,
   input  logic             esp_ack,
   output logic             esp_send,
   output logic             ticket_flag,
   output logic             led,
   output logic             cmd_mode,
   output logic             fault,
   output logic [CNT_W-1:0] ticket_count
);

   localparam int unsigned MAX_CYC = cyc_max(cyc_max(INIT_CYC, GRACE_CYC),
                                             cyc_max(PULSE_CYC, ACK_TIMEOUT_CYC));
   localparam int unsigned TW      = timer_width(MAX_CYC);

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [1:0]       ack_sync_q;
   logic             ack_s;
   logic             sensor_db, db_rise, db_fall;
   logic             retry_ok;

   logic             esp_send_q, esp_send_d;
   logic             ticket_flag_q, ticket_flag_d;
   logic             led_q, led_d;
   logic             cmd_mode_q, cmd_mode_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] count_q, count_d;

`ifdef TICKET_RETRY_EN
   localparam int unsigned RTY_W = timer_width(MAX_RETRY + 1);
   logic [RTY_W-1:0] retry_q, retry_d;
   assign retry_ok = (retry_q < RTY_W'(MAX_RETRY));
`else
   // Retry limit is forced to zero: no counter exists, every timeout faults.
   localparam int unsigned EFF_RETRY = MAX_RETRY * 0;
   assign retry_ok = (EFF_RETRY != 0);
`endif

   sensor_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debouncer (
      .clk       (clk),
      .reset     (reset),
      .sensor_in (sensor_in),
      .sensor_db (sensor_db),
      .rise      (db_rise),
      .fall      (db_fall)
   );

   // Synchronise the ESP acknowledge into clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ack_sync_q <= 2'b00;
      else       ack_sync_q <= {ack_sync_q[0], esp_ack};
   end
   assign ack_s = ack_sync_q[1];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_INIT;
      else       state_q <= state_d;
   end

   // Next-state logic; acknowledge takes priority over a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:     if (timer_q == TW'(INIT_CYC - 1)) state_d = ST_IDLE;
         ST_IDLE:     if (db_rise) state_d = ST_ARMED;
         ST_ARMED: begin
            if (db_fall)                           state_d = ST_IDLE;
            else if (timer_q == TW'(GRACE_CYC - 1)) state_d = ST_SEND;
         end
         ST_SEND: begin
            if (ack_s)                              state_d = ST_DONE;
            else if (timer_q == TW'(PULSE_CYC - 1)) state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ack_s)                                    state_d = ST_DONE;
            else if (timer_q == TW'(ACK_TIMEOUT_CYC - 1)) state_d = retry_ok ? ST_SEND : ST_FAULT;
         end
         // Level test so a car that left mid-transaction drops straight back to IDLE.
         ST_DONE:     if (!sensor_db) state_d = ST_IDLE;
         ST_FAULT:    state_d = ST_FAULT;
         default:     state_d = ST_INIT;
      endcase
   end

   // Output and datapath next values, derived from the state being entered.
   always_comb begin
      timer_d = '0;
      if (state_d == state_q) begin
         case (state_q)
            ST_INIT, ST_ARMED, ST_SEND, ST_WAIT_ACK: timer_d = timer_q + TW'(1);
            default:                                 timer_d = '0;
         endcase
      end

      esp_send_d    = (state_d == ST_SEND);
      ticket_flag_d = (state_d == ST_SEND) || (state_d == ST_WAIT_ACK) || (state_d == ST_DONE);
      cmd_mode_d    = (state_d == ST_INIT);
      fault_d       = (state_d == ST_FAULT);
      led_d         = (state_d == ST_DONE) || (state_d == ST_FAULT);

      count_d = count_q;
      if ((state_d == ST_DONE) && (state_q != ST_DONE) && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + CNT_W'(1);

`ifdef TICKET_RETRY_EN
      retry_d = retry_q;
      if ((state_q == ST_ARMED) && (state_d == ST_SEND))
         retry_d = '0;
      else if ((state_q == ST_WAIT_ACK) && (state_d == ST_SEND))
         retry_d = retry_q + RTY_W'(1);
      // Retry sends flip the led once per PULSE_CYC window, giving a visible blink.
      if ((state_d == ST_SEND) && (retry_d != '0))
         led_d = (state_q != ST_SEND) ? ~led_q : led_q;
`endif
   end

   // Registered outputs, timer and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q       <= '0;
         esp_send_q    <= 1'b0;
         ticket_flag_q <= 1'b0;
         led_q         <= 1'b0;
         cmd_mode_q    <= 1'b1;
         fault_q       <= 1'b0;
         count_q       <= '0;
`ifdef TICKET_RETRY_EN
         retry_q       <= '0;
`endif
      end else begin
         timer_q       <= timer_d;
         esp_send_q    <= esp_send_d;
         ticket_flag_q <= ticket_flag_d;
         led_q         <= led_d;
         cmd_mode_q    <= cmd_mode_d;
         fault_q       <= fault_d;
         count_q       <= count_d;
`ifdef TICKET_RETRY_EN
         retry_q       <= retry_d;
`endif
      end
   end

   assign esp_send     = esp_send_q;
   assign ticket_flag  = ticket_flag_q;
   assign led          = led_q;
   assign cmd_mode     = cmd_mode_q;
   assign fault        = fault_q;
   assign ticket_count = count_q;

endmodule
